// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multi-cycle
// results use valid/ready with a one-entry holding buffer, plus a busy-bit scoreboard.
module wb_arbiter #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_wen_i,
   input  logic [4:0]  pipe_waddr_i,
   input  logic [31:0] pipe_wdata_i,
   input  logic        mc_valid_i,
   input  logic [4:0]  mc_waddr_i,
   input  logic [31:0] mc_wdata_i,
   output logic        mc_ready_o,
   input  logic        mc_issue_i,
   input  logic [4:0]  mc_issue_rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [4:0]  rd_i,
   output logic        stall_o,
   output logic        reg_wen_o,
   output logic [4:0]  reg_waddr_o,
   output logic [31:0] reg_wdata_o
);

   localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

   logic        hold_valid_q, hold_valid_d;
   logic [4:0]  hold_addr_q;
   logic [31:0] hold_data_q;
   logic [7:0]  age_q, age_d;
   logic [31:0] busy_q, busy_d;

   logic pipe_w;
   logic handshake;
   logic capture;
   logic drain;
   logic mc_direct;
   logic commit;
   logic [4:0] commit_addr;
   logic dep_stall;
   logic wait_stall;

   assign pipe_w     = pipe_wen_i & (pipe_waddr_i != 5'd0);
   assign mc_ready_o = rst & ~hold_valid_q;
   assign handshake  = mc_valid_i & mc_ready_o;

   // A handshake implies an empty buffer, so capture and drain are exclusive.
   assign capture   = handshake & pipe_w & (mc_waddr_i != 5'd0);
   assign drain     = hold_valid_q & ~pipe_w;
   assign mc_direct = handshake & ~pipe_w & (mc_waddr_i != 5'd0);

   assign commit      = drain | mc_direct;
   assign commit_addr = drain ? hold_addr_q : mc_waddr_i;

   always_comb begin
      reg_wen_o   = 1'b0;
      reg_waddr_o = 5'd0;
      reg_wdata_o = 32'd0;
      if (rst) begin
         if (pipe_w) begin
            reg_wen_o   = 1'b1;
            reg_waddr_o = pipe_waddr_i;
            reg_wdata_o = pipe_wdata_i;
         end else if (hold_valid_q) begin
            reg_wen_o   = 1'b1;
            reg_waddr_o = hold_addr_q;
            reg_wdata_o = hold_data_q;
         end else if (mc_direct) begin
            reg_wen_o   = 1'b1;
            reg_waddr_o = mc_waddr_i;
            reg_wdata_o = mc_wdata_i;
         end
      end
   end

   always_comb begin
      hold_valid_d = hold_valid_q;
      if (capture) begin
         hold_valid_d = 1'b1;
      end else if (drain) begin
         hold_valid_d = 1'b0;
      end
   end

   always_comb begin
      age_d = age_q;
      if (!hold_valid_q || drain) begin
         age_d = 8'd0;
      end else if (age_q != 8'hFF) begin
         age_d = age_q + 8'd1;
      end
   end

   // Clear before set so a same-cycle issue to the committing register stays busy.
   always_comb begin
      busy_d = busy_q;
      if (commit) begin
         busy_d[commit_addr] = 1'b0;
      end
      if (mc_issue_i && (mc_issue_rd_i != 5'd0)) begin
         busy_d[mc_issue_rd_i] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   assign dep_stall  = busy_q[rs1_i] | busy_q[rs2_i] | busy_q[rd_i];
   assign wait_stall = hold_valid_q & (age_q >= MaxWait);
   assign stall_o    = rst & (dep_stall | wait_stall);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_valid_q <= 1'b0;
         age_q        <= 8'd0;
         busy_q       <= 32'd0;
      end else begin
         hold_valid_q <= hold_valid_d;
         age_q        <= age_d;
         busy_q       <= busy_d;
      end
   end

   // NOTE: the held address/data are qualified by hold_valid_q, so they need
   // no reset and are simply loaded on capture.
   always_ff @(posedge clk) begin
      if (capture) begin
         hold_addr_q <= mc_waddr_i;
         hold_data_q <= mc_wdata_i;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: one task per scenario, inline comparisons.
module tb_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        pipe_wen_i;
   logic [4:0]  pipe_waddr_i;
   logic [31:0] pipe_wdata_i;
   logic        mc_valid_i;
   logic [4:0]  mc_waddr_i;
   logic [31:0] mc_wdata_i;
   logic        mc_ready_o;
   logic        mc_issue_i;
   logic [4:0]  mc_issue_rd_i;
   logic [4:0]  rs1_i;
   logic [4:0]  rs2_i;
   logic [4:0]  rd_i;
   logic        stall_o;
   logic        reg_wen_o;
   logic [4:0]  reg_waddr_o;
   logic [31:0] reg_wdata_o;

   int tests_run;
   int tests_failed;

   wb_arbiter #(.MAX_WAIT(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .pipe_wen_i   (pipe_wen_i),
      .pipe_waddr_i (pipe_waddr_i),
      .pipe_wdata_i (pipe_wdata_i),
      .mc_valid_i   (mc_valid_i),
      .mc_waddr_i   (mc_waddr_i),
      .mc_wdata_i   (mc_wdata_i),
      .mc_ready_o   (mc_ready_o),
      .mc_issue_i   (mc_issue_i),
      .mc_issue_rd_i(mc_issue_rd_i),
      .rs1_i        (rs1_i),
      .rs2_i        (rs2_i),
      .rd_i         (rd_i),
      .stall_o      (stall_o),
      .reg_wen_o    (reg_wen_o),
      .reg_waddr_o  (reg_waddr_o),
      .reg_wdata_o  (reg_wdata_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs change and checks happen mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle_inputs();
      pipe_wen_i    = 1'b0;
      pipe_waddr_i  = 5'd0;
      pipe_wdata_i  = 32'd0;
      mc_valid_i    = 1'b0;
      mc_waddr_i    = 5'd0;
      mc_wdata_i    = 32'd0;
      mc_issue_i    = 1'b0;
      mc_issue_rd_i = 5'd0;
      rs1_i         = 5'd0;
      rs2_i         = 5'd0;
      rd_i          = 5'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      pipe_wen_i   = 1'b1;
      pipe_waddr_i = 5'd3;
      pipe_wdata_i = 32'h55;
      mc_valid_i   = 1'b1;
      mc_waddr_i   = 5'd4;
      tick();
      tests_run++;
      if ({reg_wen_o, reg_waddr_o, reg_wdata_o} !== 38'd0) begin
         tests_failed++;
         $display("FAIL reset_write_port: got wen=%b addr=%0d data=%h, want 0/0/0",
                  reg_wen_o, reg_waddr_o, reg_wdata_o);
      end
      tests_run++;
      if (mc_ready_o !== 1'b0 || stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_ready_stall: got ready=%b stall=%b, want 0/0", mc_ready_o, stall_o);
      end
      idle_inputs();
      @(negedge clk);
      rst = 1'b1;
      tick();
      tests_run++;
      if (mc_ready_o !== 1'b1 || stall_o !== 1'b0 || reg_wen_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_release: got ready=%b stall=%b wen=%b, want 1/0/0",
                  mc_ready_o, stall_o, reg_wen_o);
      end
   endtask

   task automatic test_direct_write();
      mc_issue_i    = 1'b1;
      mc_issue_rd_i = 5'd5;
      tick();
      mc_issue_i = 1'b0;
      rs1_i      = 5'd5;
      mc_valid_i = 1'b1;
      mc_waddr_i = 5'd5;
      mc_wdata_i = 32'h1234;
      settle();
      tests_run++;
      if (reg_wen_o !== 1'b1 || reg_waddr_o !== 5'd5 || reg_wdata_o !== 32'h1234) begin
         tests_failed++;
         $display("FAIL direct_write: got wen=%b addr=%0d data=%h, want 1/5/00001234",
                  reg_wen_o, reg_waddr_o, reg_wdata_o);
      end
      tests_run++;
      if (mc_ready_o !== 1'b1 || stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL direct_commit_cycle: got ready=%b stall=%b, want 1/1", mc_ready_o, stall_o);
      end
      tick();
      mc_valid_i = 1'b0;
      settle();
      tests_run++;
      if (stall_o !== 1'b0 || reg_wen_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL direct_busy_clear: got stall=%b wen=%b, want 0/0", stall_o, reg_wen_o);
      end
      idle_inputs();
   endtask

   task automatic test_conflict();
      pipe_wen_i   = 1'b1;
      pipe_waddr_i = 5'd3;
      pipe_wdata_i = 32'hA;
      mc_valid_i   = 1'b1;
      mc_waddr_i   = 5'd7;
      mc_wdata_i   = 32'hB;
      settle();
      tests_run++;
      if (reg_wen_o !== 1'b1 || reg_waddr_o !== 5'd3 || reg_wdata_o !== 32'hA || mc_ready_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL conflict_pipe_wins: got wen=%b addr=%0d data=%h ready=%b, want 1/3/0000000a/1",
                  reg_wen_o, reg_waddr_o, reg_wdata_o, mc_ready_o);
      end
      tick();
      idle_inputs();
      settle();
      tests_run++;
      if (mc_ready_o !== 1'b0 || reg_wen_o !== 1'b1 || reg_waddr_o !== 5'd7 || reg_wdata_o !== 32'hB) begin
         tests_failed++;
         $display("FAIL conflict_drain: got ready=%b wen=%b addr=%0d data=%h, want 0/1/7/0000000b",
                  mc_ready_o, reg_wen_o, reg_waddr_o, reg_wdata_o);
      end
      tick();
      tests_run++;
      if (mc_ready_o !== 1'b1 || reg_wen_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL conflict_after_drain: got ready=%b wen=%b, want 1/0", mc_ready_o, reg_wen_o);
      end
   endtask

   task automatic test_scoreboard();
      mc_issue_i    = 1'b1;
      mc_issue_rd_i = 5'd9;
      tick();
      mc_issue_i = 1'b0;
      rs1_i      = 5'd9;
      settle();
      tests_run++;
      if (stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL sb_rs1: got stall=%b, want 1", stall_o);
      end
      rs1_i = 5'd0;
      rs2_i = 5'd9;
      settle();
      tests_run++;
      if (stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL sb_rs2: got stall=%b, want 1", stall_o);
      end
      rs2_i = 5'd0;
      rd_i  = 5'd9;
      settle();
      tests_run++;
      if (stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL sb_rd: got stall=%b, want 1", stall_o);
      end
      rd_i  = 5'd8;
      rs1_i = 5'd10;
      settle();
      tests_run++;
      if (stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_unrelated: got stall=%b, want 0", stall_o);
      end
      rd_i       = 5'd0;
      rs1_i      = 5'd9;
      mc_valid_i = 1'b1;
      mc_waddr_i = 5'd9;
      mc_wdata_i = 32'h99;
      settle();
      tests_run++;
      if (stall_o !== 1'b1 || reg_wen_o !== 1'b1 || reg_waddr_o !== 5'd9) begin
         tests_failed++;
         $display("FAIL sb_commit_cycle: got stall=%b wen=%b addr=%0d, want 1/1/9",
                  stall_o, reg_wen_o, reg_waddr_o);
      end
      tick();
      mc_valid_i = 1'b0;
      settle();
      tests_run++;
      if (stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL sb_after_commit: got stall=%b, want 0", stall_o);
      end
      idle_inputs();
   endtask

   task automatic test_starvation();
      pipe_wen_i   = 1'b1;
      pipe_waddr_i = 5'd1;
      pipe_wdata_i = 32'h1;
      mc_valid_i   = 1'b1;
      mc_waddr_i   = 5'd12;
      mc_wdata_i   = 32'hC;
      tick();
      mc_valid_i = 1'b0;
      mc_waddr_i = 5'd0;
      mc_wdata_i = 32'd0;
      for (int i = 0; i < 4; i++) begin
         settle();
         tests_run++;
         if (stall_o !== 1'b0 || mc_ready_o !== 1'b0 || reg_waddr_o !== 5'd1) begin
            tests_failed++;
            $display("FAIL starve_wait_%0d: got stall=%b ready=%b addr=%0d, want 0/0/1",
                     i, stall_o, mc_ready_o, reg_waddr_o);
         end
         tick();
      end
      tests_run++;
      if (stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL starve_forced: got stall=%b, want 1", stall_o);
      end
      tick();
      tests_run++;
      if (stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL starve_hold: got stall=%b, want 1", stall_o);
      end
      pipe_wen_i = 1'b0;
      settle();
      tests_run++;
      if (reg_wen_o !== 1'b1 || reg_waddr_o !== 5'd12 || reg_wdata_o !== 32'hC || stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL starve_drain: got wen=%b addr=%0d data=%h stall=%b, want 1/12/0000000c/1",
                  reg_wen_o, reg_waddr_o, reg_wdata_o, stall_o);
      end
      tick();
      tests_run++;
      if (stall_o !== 1'b0 || mc_ready_o !== 1'b1 || reg_wen_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL starve_release: got stall=%b ready=%b wen=%b, want 0/1/0",
                  stall_o, mc_ready_o, reg_wen_o);
      end
      idle_inputs();
   endtask

   task automatic test_edges();
      pipe_wen_i   = 1'b1;
      pipe_waddr_i = 5'd0;
      pipe_wdata_i = 32'hDEAD;
      mc_valid_i   = 1'b1;
      mc_waddr_i   = 5'd4;
      mc_wdata_i   = 32'h44;
      settle();
      tests_run++;
      if (reg_wen_o !== 1'b1 || reg_waddr_o !== 5'd4 || reg_wdata_o !== 32'h44) begin
         tests_failed++;
         $display("FAIL edge_pipe_x0: got wen=%b addr=%0d data=%h, want 1/4/00000044",
                  reg_wen_o, reg_waddr_o, reg_wdata_o);
      end
      tick();
      idle_inputs();
      mc_valid_i = 1'b1;
      mc_waddr_i = 5'd0;
      mc_wdata_i = 32'hFF;
      settle();
      tests_run++;
      if (mc_ready_o !== 1'b1 || reg_wen_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL edge_mc_x0: got ready=%b wen=%b, want 1/0", mc_ready_o, reg_wen_o);
      end
      tick();
      mc_valid_i = 1'b0;
      settle();
      tests_run++;
      if (mc_ready_o !== 1'b1 || reg_wen_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL edge_mc_x0_discard: got ready=%b wen=%b, want 1/0", mc_ready_o, reg_wen_o);
      end
      mc_issue_i    = 1'b1;
      mc_issue_rd_i = 5'd6;
      tick();
      mc_valid_i = 1'b1;
      mc_waddr_i = 5'd6;
      mc_wdata_i = 32'h66;
      tick();
      idle_inputs();
      rd_i = 5'd6;
      settle();
      tests_run++;
      if (stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL edge_set_wins: got stall=%b, want 1", stall_o);
      end
      mc_valid_i = 1'b1;
      mc_waddr_i = 5'd6;
      mc_wdata_i = 32'h67;
      tick();
      mc_valid_i = 1'b0;
      settle();
      tests_run++;
      if (stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL edge_second_commit: got stall=%b, want 0", stall_o);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_buffer();
      pipe_wen_i    = 1'b1;
      pipe_waddr_i  = 5'd2;
      pipe_wdata_i  = 32'h2;
      mc_valid_i    = 1'b1;
      mc_waddr_i    = 5'd8;
      mc_wdata_i    = 32'h88;
      mc_issue_i    = 1'b1;
      mc_issue_rd_i = 5'd10;
      tick();
      mc_valid_i = 1'b0;
      mc_issue_i = 1'b0;
      rs1_i      = 5'd10;
      settle();
      tests_run++;
      if (mc_ready_o !== 1'b0 || stall_o !== 1'b1) begin
         tests_failed++;
         $display("FAIL rstmid_before: got ready=%b stall=%b, want 0/1", mc_ready_o, stall_o);
      end
      rst = 1'b0;
      settle();
      tests_run++;
      if (reg_wen_o !== 1'b0 || reg_waddr_o !== 5'd0 || reg_wdata_o !== 32'd0 ||
          mc_ready_o !== 1'b0 || stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_async: got wen=%b addr=%0d data=%h ready=%b stall=%b, want all 0",
                  reg_wen_o, reg_waddr_o, reg_wdata_o, mc_ready_o, stall_o);
      end
      @(negedge clk);
      rst        = 1'b1;
      pipe_wen_i = 1'b0;
      tick();
      tests_run++;
      if (mc_ready_o !== 1'b1 || reg_wen_o !== 1'b0 || stall_o !== 1'b0) begin
         tests_failed++;
         $display("FAIL rstmid_after: got ready=%b wen=%b stall=%b, want 1/0/0",
                  mc_ready_o, reg_wen_o, stall_o);
      end
      idle_inputs();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_direct_write();
      test_conflict();
      test_scoreboard();
      test_starvation();
      test_edges();
      test_reset_mid_buffer();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-port arbiter and scoreboard for the 32×32 integer register file. It shares the file's single write port between two sources. The in-order pipeline writeback always has priority and is never back-pressured. The multi-cycle unit result port uses valid/ready handshaking and has a one-entry holding buffer. A busy-bit scoreboard tracks registers with outstanding multi-cycle writes and produces the decode stall.

## Interface
Parameters:
- MAX_WAIT, 4 — cycles a buffered result may wait before the decode stall is forced (range 1–255).

Ports:
- clk  in  1  — system clock; all state updates on the rising edge.
- rst  in  1  — reset, asynchronous, active-low; one clock only.
- pipe_wen_i  in  1  — pipeline writeback write enable.
- pipe_waddr_i  in  5  — pipeline writeback destination register.
- pipe_wdata_i  in  32  — pipeline writeback data.
- mc_valid_i  in  1  — multi-cycle result valid.
- mc_waddr_i  in  5  — multi-cycle result destination register.
- mc_wdata_i  in  32  — multi-cycle result data.
- mc_ready_o  out  1  — arbiter can accept a multi-cycle result.
- mc_issue_i  in  1  — a multi-cycle op leaves decode this cycle.
- mc_issue_rd_i  in  5  — destination of the issued op.
- rs1_i  in  5  — decode source register 1 (0 means unused).
- rs2_i  in  5  — decode source register 2 (0 means unused).
- rd_i  in  5  — decode destination register (0 means unused).
- stall_o  out  1  — hold decode.
- reg_wen_o  out  1  — register file write enable.
- reg_waddr_o  out  5  — register file write address.
- reg_wdata_o  out  32  — register file write data.

## Operation
State:
- hold_valid, hold_addr[4:0], hold_data[31:0] — the holding buffer.
- age[7:0] — wait counter for the buffered result.
- busy[31:1] — scoreboard bits; busy[0] is constant 0.

Definitions:
- pipe_w = pipe_wen_i & (pipe_waddr_i != 0).
- mc_ready_o = rst & ~hold_valid.
- A handshake occurs when mc_valid_i & mc_ready_o.

Write select (combinational, in priority order):
- If pipe_w: write the pipe source.
- Else if hold_valid: write from the hold buffer (drain).
- Else if handshake and mc_waddr_i != 0: write the mc source directly.
- Else: reg_wen_o = 0, reg_waddr_o = 0, reg_wdata_o = 0.
- A pipe write to x0 does not occupy the port.

Hold buffer:
- Capture on handshake & pipe_w & (mc_waddr_i != 0): hold_valid ← 1; store address and data.
- Handshake with mc_waddr_i == 0: accepted and discarded; nothing is written or buffered.
- Drain on hold_valid & ~pipe_w: hold_valid ← 0.
- Capture and drain in the same cycle cannot occur, because a handshake requires hold_valid = 0.

Wait counter:
- age ← 0 when hold_valid is 0 or the buffer drains.
- Otherwise age increments, saturating at 255.

Scoreboard:
- mc commit = a drain, or a direct mc write with nonzero address.
- Set: mc_issue_i & (mc_issue_rd_i != 0) sets busy[mc_issue_rd_i].
- Clear: a commit clears busy[commit address].
- Set and clear of the same register in the same cycle: set wins.
- Re-issue to an already busy register: the bit stays set and is cleared by the first commit. Decode prevents this case through the rd_i check.

Stall:
- stall_o = (rs1_i != 0 & busy[rs1_i]) | (rs2_i != 0 & busy[rs2_i]) | (rd_i != 0 & busy[rd_i]) | (hold_valid & age ≥ MAX_WAIT).
- stall_o uses registered busy, so it stays high during the commit cycle and drops the cycle after the value is in the register file.
- A forced stall drains the pipeline until pipe_w drops, which lets the buffer drain.

## Timing
- Reset (rst low), asynchronous: hold_valid = 0, age = 0, busy = 0.
- Outputs held during reset: mc_ready_o = 0, reg_wen_o = 0, reg_waddr_o = 0, reg_wdata_o = 0, stall_o = 0.
- Reset mid-buffer discards the held result.
- reg_w* outputs are combinational; the register file commits them at the next rising edge.
- Port free: mc result latency is 0 cycles, written at the edge that ends the handshake cycle.
- Port busy: result is buffered; it commits in the first cycle with ~pipe_w.
- Forced stall: asserted once age reaches MAX_WAIT (MAX_WAIT cycles after capture).
- Throughput: one mc result per cycle when the pipe is idle.
- While the buffer is full, mc_ready_o = 0 and the unit must hold its result.
- mc_valid_i, mc_waddr_i and mc_wdata_i must stay stable until the handshake completes.

## Test plan
1. Reset release, then mc_valid_i = 1, x5 = 0x1234, pipe idle → same-cycle reg_wen_o = 1, addr 5, data 0x1234; mc_ready_o = 1; busy[5] cleared at the next edge.
2. Conflict: pipe writes x3 = 0xA and mc offers x7 = 0xB in the same cycle → pipe write to x3; hold captures x7; next cycle mc_ready_o = 0 and, with pipe idle, x7 = 0xB is written.
3. Scoreboard: issue mc to rd = 9; next cycle rs1_i = 9 → stall_o = 1. Commit x9 → stall_o still 1 in the commit cycle, 0 on the following cycle.
4. Starvation with MAX_WAIT = 4: buffer filled while pipe_w is held high → stall_o rises 4 cycles after capture. pipe_w then drops → drain, age resets, stall_o falls.
5. Edge cases: pipe_wen_i = 1 with addr 0 while mc offers x4 → x4 written directly. mc result to x0 → accepted, nothing written. Same-cycle issue and commit of x6 → busy[6] = 1 afterward.
6. Reset asserted while hold_valid = 1 → outputs go to 0 immediately; after release mc_ready_o = 1 and busy = 0.
